// File: rtl/rca_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rca / rca_arbiter
//
// rca: combinational ripple-carry adder built from a chain of full adders.
//   a_i    in   WIDTH     operand A
//   b_i    in   WIDTH     operand B
//   sum_o  out  WIDTH+1   a_i + b_i, carry-out in the MSB
//
// rca_arbiter: shares one rca among NREQ requesters. A round-robin scan picks
// the winner, the winner's operands feed the rca, and the sum is captured in
// a single-entry output register tagged with the winner's index.
//   clk_i        in   1            clock, rising edge
//   rst_ni       in   1            asynchronous reset, active-low
//   req_valid_i  in   NREQ         per-requester operand valid
//   req_ready_o  out  NREQ         per-requester accept (one-hot or zero)
//   req_a_i      in   NREQ*WIDTH   operand A, requester k at [k*WIDTH +: WIDTH]
//   req_b_i      in   NREQ*WIDTH   operand B, same packing
//   rsp_valid_o  out  1            result register holds a valid sum
//   rsp_ready_i  in   1            consumer accepts the result
//   rsp_sum_o    out  WIDTH+1      captured sum
//   rsp_id_o     out  IDW          requester that produced the sum
//   ops_cnt_o    out  16           completed-response counter (wraps)
// ---------------------------------------------------------------------------
module rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign sum_o[WIDTH] = carry[WIDTH];

endmodule

module rca_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH:0]        rsp_sum_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [15:0]           ops_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_reg;
  logic [WIDTH:0] sum_reg;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] ptr_reg;
  logic [15:0]    cnt_reg;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW:0]   scan_idx;
  logic           can_accept;
  logic           grant;
  logic           consume;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   rca_sum;

  // Round-robin scan: start at ptr_reg and wrap modulo NREQ. The index is
  // one bit wider so the wrap also works when NREQ is not a power of two.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr_reg} + (IDW + 1)'(i);
      if (scan_idx >= (IDW + 1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW + 1)'(NREQ);
      end
      if (!found && req_valid_i[scan_idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IDW-1:0];
      end
    end
  end

  // Operand mux; zero when nobody is requesting.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (found && winner == IDW'(k)) begin
        op_a = req_a_i[k*WIDTH +: WIDTH];
        op_b = req_b_i[k*WIDTH +: WIDTH];
      end
    end
  end

  rca #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (rca_sum)
  );

  // The result slot is free if empty or being drained this cycle.
  assign can_accept = (state_reg == EMPTY) | rsp_ready_i;
  // rst_ni gates the grant so no ready is shown while reset is held.
  assign grant      = found & can_accept & rst_ni;
  assign consume    = (state_reg == FULL) & rsp_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready_o[gi] = grant & (winner == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= EMPTY;
      sum_reg   <= '0;
      id_reg    <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      if (consume) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
      if (grant) begin
        // Covers both EMPTY->FULL and consume+accept (FULL->FULL).
        state_reg <= FULL;
        sum_reg   <= rca_sum;
        id_reg    <= winner;
        ptr_reg   <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end else if (consume) begin
        state_reg <= EMPTY;
      end
    end
  end

  assign rsp_valid_o = (state_reg == FULL);
  assign rsp_sum_o   = sum_reg;
  assign rsp_id_o    = id_reg;
  assign ops_cnt_o   = cnt_reg;

endmodule

// File: tb/tb_rca_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for rca_arbiter (WIDTH=8, NREQ=4). Expected responses
// are pushed to a scoreboard queue when a grant is expected and popped when
// the result register presents them. Inputs change on the falling edge and
// outputs are sampled there too, away from the active rising edge.
module tb_rca_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic [15:0] ops_cnt;

  typedef struct packed {
    logic [8:0] sum;
    logic [1:0] id;
  } exp_t;

  exp_t sbq[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  rca_arbiter #(
    .WIDTH (8),
    .NREQ  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_sum_o   (rsp_sum),
    .rsp_id_o    (rsp_id),
    .ops_cnt_o   (ops_cnt)
  );

  // Expected result for requester k from the operands the bench is driving.
  function automatic exp_t mk_exp(int k);
    exp_t e;
    e.sum = {1'b0, req_a[k*8 +: 8]} + {1'b0, req_b[k*8 +: 8]};
    e.id  = 2'(k);
    return e;
  endfunction

  function automatic exp_t mk_lit(logic [8:0] s, logic [1:0] id);
    exp_t e;
    e.sum = s;
    e.id  = id;
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a     = $urandom;
    req_b     = $urandom;
    repeat (2) @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_sum !== 9'd0) $display("FAIL reset_sum got=%h exp=000", rsp_sum); else pass_cnt++;
    total_cnt++; if (rsp_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", rsp_id); else pass_cnt++;
    total_cnt++; if (ops_cnt !== 16'd0) $display("FAIL reset_cnt got=%h exp=0000", ops_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else pass_cnt++;
    rst_n     = 1'b1;
    req_valid = '0;
    $display("txn reset done");
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    req_valid       = 4'b0001;
    req_a[7:0]      = 8'd200;
    req_b[7:0]      = 8'd100;
    rsp_ready       = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else pass_cnt++;
    sbq.push_back(mk_lit(9'h12C, 2'd0));
    @(negedge clk);
    req_valid = '0;
    e = sbq.pop_front();
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL single_sum got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    total_cnt++; if (rsp_id !== e.id) $display("FAIL single_id got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    $display("txn single id=%0d sum=%h", rsp_id, rsp_sum);
    #1;
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL single_idle_ready got=%b exp=0000", req_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (ops_cnt !== 16'd1) $display("FAIL single_cnt got=%0d exp=1", ops_cnt); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    exp_t       e;
    logic [3:0] exp_ready;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sbq.pop_front();
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rr_valid cyc=%0d got=%b exp=1", i, rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_sum !== e.sum) $display("FAIL rr_sum cyc=%0d got=%h exp=%h", i, rsp_sum, e.sum); else pass_cnt++;
        total_cnt++; if (rsp_id !== e.id) $display("FAIL rr_id cyc=%0d got=%0d exp=%0d", i, rsp_id, e.id); else pass_cnt++;
        $display("txn rr id=%0d sum=%h", rsp_id, rsp_sum);
      end
      if (i < 6) begin
        req_a     = $urandom;
        req_b     = $urandom;
        req_valid = 4'hF;
        #1;
        exp_ready = 4'(1 << (i % 4));
        total_cnt++; if (req_ready !== exp_ready) $display("FAIL rr_ready cyc=%0d got=%b exp=%b", i, req_ready, exp_ready); else pass_cnt++;
        sbq.push_back(mk_exp(i % 4));
      end else begin
        req_valid = '0;
      end
    end
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rr_drain got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (ops_cnt !== 16'd6) $display("FAIL rr_cnt got=%0d exp=6", ops_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    exp_t e;
    @(negedge clk);
    req_valid    = 4'b0100;
    req_a[23:16] = 8'd255;
    req_b[23:16] = 8'd255;
    #1;
    total_cnt++; if (req_ready !== 4'b0100) $display("FAIL ovf_ready0 got=%b exp=0100", req_ready); else pass_cnt++;
    sbq.push_back(mk_lit(9'h1FE, 2'd2));
    @(negedge clk);
    e = sbq.pop_front();
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL ovf_sum got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    total_cnt++; if (rsp_id !== e.id) $display("FAIL ovf_id got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    $display("txn overflow id=%0d sum=%h", rsp_id, rsp_sum);
    req_a[23:16] = 8'd0;
    req_b[23:16] = 8'd0;
    #1;
    total_cnt++; if (req_ready !== 4'b0100) $display("FAIL ovf_ready1 got=%b exp=0100", req_ready); else pass_cnt++;
    sbq.push_back(mk_lit(9'h000, 2'd2));
    @(negedge clk);
    req_valid = '0;
    e = sbq.pop_front();
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL zero_sum got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    total_cnt++; if (rsp_id !== e.id) $display("FAIL zero_id got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    $display("txn zero id=%0d sum=%h", rsp_id, rsp_sum);
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL ovf_drain got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    // ptr is at 3 after the overflow test.
    @(negedge clk);
    req_a     = $urandom;
    req_b     = $urandom;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 4'b1000) $display("FAIL bp_ready_first got=%b exp=1000", req_ready); else pass_cnt++;
    sbq.push_back(mk_exp(3));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_sum !== sbq[0].sum) $display("FAIL bp_sum cyc=%0d got=%h exp=%h", i, rsp_sum, sbq[0].sum); else pass_cnt++;
      total_cnt++; if (rsp_id !== sbq[0].id) $display("FAIL bp_id cyc=%0d got=%0d exp=%0d", i, rsp_id, sbq[0].id); else pass_cnt++;
      #1;
      total_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0000", i, req_ready); else pass_cnt++;
    end
    @(negedge clk);
    e = sbq.pop_front();
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL bp_release_sum got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    total_cnt++; if (rsp_id !== e.id) $display("FAIL bp_release_id got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    $display("txn backpressure id=%0d sum=%h", rsp_id, rsp_sum);
    rsp_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 4'b0001) $display("FAIL bp_release_ready got=%b exp=0001", req_ready); else pass_cnt++;
    sbq.push_back(mk_exp(0));
    @(negedge clk);
    req_valid = '0;
    e = sbq.pop_front();
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_next_valid got=%b exp=1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL bp_next_sum got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    total_cnt++; if (rsp_id !== e.id) $display("FAIL bp_next_id got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    $display("txn backpressure id=%0d sum=%h", rsp_id, rsp_sum);
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // ptr is at 1 after the backpressure test.
    @(negedge clk);
    req_a     = $urandom;
    req_b     = $urandom;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 4'b0010) $display("FAIL rmid_ready got=%b exp=0010", req_ready); else pass_cnt++;
    sbq.push_back(mk_exp(1));
    @(negedge clk);
    rsp_ready = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rmid_full got=%b exp=1", rsp_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (ops_cnt !== 16'd0) $display("FAIL rmid_cnt got=%0d exp=0", ops_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rmid_ready_rst got=%b exp=0000", req_ready); else pass_cnt++;
    sbq.delete();
    $display("txn reset_mid result discarded");
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    #1;
    total_cnt++; if (req_ready !== 4'b0001) $display("FAIL rmid_first got=%b exp=0001", req_ready); else pass_cnt++;
    sbq.push_back(mk_exp(0));
    @(negedge clk);
    req_valid = 4'b0010;
    e = sbq.pop_front();
    total_cnt++; if (rsp_id !== e.id) $display("FAIL rmid_id0 got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL rmid_sum0 got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    $display("txn reset_mid id=%0d sum=%h", rsp_id, rsp_sum);
    #1;
    total_cnt++; if (req_ready !== 4'b0010) $display("FAIL rmid_second got=%b exp=0010", req_ready); else pass_cnt++;
    sbq.push_back(mk_exp(1));
    @(negedge clk);
    req_valid = '0;
    e = sbq.pop_front();
    total_cnt++; if (rsp_id !== e.id) $display("FAIL rmid_id1 got=%0d exp=%0d", rsp_id, e.id); else pass_cnt++;
    total_cnt++; if (rsp_sum !== e.sum) $display("FAIL rmid_sum1 got=%h exp=%h", rsp_sum, e.sum); else pass_cnt++;
    $display("txn reset_mid id=%0d sum=%h", rsp_id, rsp_sum);
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rmid_drain got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    exp_t        e;
    logic [15:0] ab;
    int          bad = 0;
    apply_reset();
    for (int n = 0; n <= 65536; n++) begin
      @(negedge clk);
      if (n > 0) begin
        e = sbq.pop_front();
        total_cnt++; if (rsp_sum !== e.sum) begin bad++; $display("FAIL exh_sum n=%0d got=%h exp=%h", n - 1, rsp_sum, e.sum); end else pass_cnt++;
        total_cnt++; if (rsp_id !== e.id) begin bad++; $display("FAIL exh_id n=%0d got=%0d exp=%0d", n - 1, rsp_id, e.id); end else pass_cnt++;
      end
      if (n > 0 && (n % 4096) == 0) begin
        // n grants so far; the latest response is on display, n-1 consumed.
        total_cnt++; if (ops_cnt !== 16'(n - 1)) $display("FAIL exh_cnt n=%0d got=%h exp=%h", n, ops_cnt, 16'(n - 1)); else pass_cnt++;
      end
      if (n < 65536) begin
        ab           = 16'(n);
        req_valid    = 4'b1000;
        req_a[31:24] = ab[15:8];
        req_b[31:24] = ab[7:0];
        #1;
        total_cnt++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL exh_ready n=%0d got=%b exp=1000", n, req_ready); end else pass_cnt++;
        sbq.push_back(mk_lit({1'b0, ab[15:8]} + {1'b0, ab[7:0]}, 2'd3));
      end else begin
        req_valid = '0;
      end
    end
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL exh_drain got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (ops_cnt !== 16'd0) $display("FAIL exh_wrap got=%h exp=0000", ops_cnt); else pass_cnt++;
    $display("txn exhaustive responses=65536 bad=%0d cnt=%h", bad, ops_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
